// File: rtl/axi4l_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_pkg
// Description : Shared types for the AXI4-Lite RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4l_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRESP = 2'd1,
      RRESP = 2'd2
   } axi4l_ram_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4l_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_if
// Description : AXI4-Lite bus, 32-bit address and data, master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4l_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi4l_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_ram_array
// Description : Single-port DEPTH x 32 byte-writable RAM, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4l_ram_array #(
    parameter int unsigned DEPTH     = 16384,
    parameter              INIT_FILE = "",
    localparam int unsigned c_AW     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_en,
    input  logic [3:0]      i_we,
    input  logic [c_AW-1:0] i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read register only updates on pure reads so it stays stable across writes.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            if (i_we == 4'b0000) r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4l_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_ram
// Description : AXI4-Lite slave memory, one transaction at a time with
//               alternating write/read arbitration. Define
//               AXI4L_RAM_RANGE_CHECK_EN to return SLVERR outside the window.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4l_ram
   import axi4l_pkg::*;
#(
   parameter int unsigned DEPTH     = 16384,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic   clk,
   input  logic   rst,
   axi4l_if.slave axi
);

   localparam int unsigned c_AW   = $clog2(DEPTH);
   localparam logic [33:0] c_SPAN = 34'(DEPTH) << 2;

   axi4l_ram_state_e r_state;
   axi4l_ram_state_e w_next;
   logic             r_last_wr;
   resp_t            r_bresp;
   resp_t            r_rresp;
   logic             r_rd_ok;

   logic [31:0]     w_aw_off;
   logic [31:0]     w_ar_off;
   logic [c_AW-1:0] w_aw_idx;
   logic [c_AW-1:0] w_ar_idx;
   logic            w_aw_ok;
   logic            w_ar_ok;
   logic            w_idle;
   logic            w_wr_req;
   logic            w_rd_req;
   logic            w_grant_wr;
   logic            w_grant_rd;
   logic            w_awready;
   logic            w_arready;
   logic [c_AW-1:0] w_arr_addr;
   logic [3:0]      w_arr_we;
   logic            w_arr_en;
   logic [31:0]     w_arr_rdata;
   logic            w_unused_bits;

   assign w_aw_off = axi.awaddr - BASE_ADDR;
   assign w_ar_off = axi.araddr - BASE_ADDR;
   assign w_aw_idx = w_aw_off[c_AW+1:2];
   assign w_ar_idx = w_ar_off[c_AW+1:2];

`ifdef AXI4L_RAM_RANGE_CHECK_EN
   // Addresses below the base wrap to huge offsets, so one compare covers both ends.
   assign w_aw_ok = ({2'b00, w_aw_off} < c_SPAN);
   assign w_ar_ok = ({2'b00, w_ar_off} < c_SPAN);
`else
   assign w_aw_ok = 1'b1;
   assign w_ar_ok = 1'b1;
`endif

   assign w_unused_bits = ^{axi.awprot, axi.arprot, w_aw_off, w_ar_off};

   assign w_idle     = (r_state == IDLE) && !rst;
   assign w_wr_req   = axi.awvalid && axi.wvalid;
   assign w_rd_req   = axi.arvalid;
   assign w_grant_wr = w_idle && w_wr_req && (!w_rd_req || !r_last_wr);
   assign w_grant_rd = w_idle && w_rd_req && !w_grant_wr;

   assign w_arr_en   = w_grant_wr || w_grant_rd;
   assign w_arr_addr = w_grant_wr ? w_aw_idx : w_ar_idx;
   assign w_arr_we   = (w_grant_wr && w_aw_ok) ? axi.wstrb : 4'b0000;

   axi4l_ram_array #(
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk     (clk),
      .i_en    (w_arr_en),
      .i_we    (w_arr_we),
      .i_addr  (w_arr_addr),
      .i_wdata (axi.wdata),
      .o_rdata (w_arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last_wr <= 1'b0;
         r_bresp   <= OKAY;
         r_rresp   <= OKAY;
         r_rd_ok   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant_wr) begin
            r_last_wr <= 1'b1;
            r_bresp   <= w_aw_ok ? OKAY : SLVERR;
         end
         if (w_grant_rd) begin
            r_last_wr <= 1'b0;
            r_rresp   <= w_ar_ok ? OKAY : SLVERR;
            r_rd_ok   <= w_ar_ok;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_awready = 1'b0;
      w_arready = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_wr) begin
               w_awready = 1'b1;
               w_next    = WRESP;
            end else if (w_grant_rd) begin
               w_arready = 1'b1;
               w_next    = RRESP;
            end
         end
         WRESP:   if (axi.bready) w_next = IDLE;
         RRESP:   if (axi.rready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign axi.awready = w_awready;
   assign axi.wready  = w_awready;
   assign axi.arready = w_arready;
   assign axi.bvalid  = (r_state == WRESP);
   assign axi.rvalid  = (r_state == RRESP);
   assign axi.bresp   = r_bresp;
   assign axi.rresp   = r_rresp;
   // Out-of-range reads and the post-reset state present zero data.
   assign axi.rdata   = r_rd_ok ? w_arr_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_axi4l_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4l_ram
// Description : Self-checking bench for axi4l_ram (DEPTH=16, non-zero base).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4l_ram;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef AXI4L_RAM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4l_if axi ();

   axi4l_ram #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE),
      .INIT_FILE ("")
   ) dut (
      .clk (clk),
      .rst (rst),
      .axi (axi)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mdl [DEPTH];
   vec_t        tbl [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'(4 * DEPTH);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off >> 2) & 32'(DEPTH - 1));
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return (RC && !in_rng(a)) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] a);
      return (RC && !in_rng(a)) ? 32'h0 : mdl[idx_of(a)];
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (!RC || in_rng(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx_of(a)][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      n = 0;
      #1;
      while (!(axi.awready && axi.wready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("wr_grant", 32'(axi.awready && axi.wready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      #1;
      chk("bvalid_lat", 32'(axi.bvalid), 32'd1);
      resp = axi.bresp;
      axi.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.bready = 1'b0;
      #1;
      chk("bvalid_drop", 32'(axi.bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] data);
      int n;
      @(negedge clk);
      axi.araddr = a; axi.arvalid = 1'b1;
      n = 0;
      #1;
      while (!axi.arready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("rd_grant", 32'(axi.arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.arvalid = 1'b0;
      #1;
      chk("rvalid_lat", 32'(axi.rvalid), 32'd1);
      resp = axi.rresp;
      data = axi.rdata;
      axi.rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      logic [31:0] a;
      logic [3:0]  s;
      logic [3:0]  g;
      int          got;

      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      // Reset: requests pending during reset must not be granted.
      repeat (2) @(negedge clk);
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
      chk("rst_valids", 32'({axi.bvalid, axi.rvalid}), 32'd0);
      chk("rst_resps", 32'({axi.bresp, axi.rresp}), 32'd0);
      chk("rst_rdata", axi.rdata, 32'd0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         axi_write(BASE + 32'(4 * i), d, 4'hF, r);
         chk("init_bresp", 32'(r), 32'd0);
         mdl_write(BASE + 32'(4 * i), d, 4'hF);
      end

      tbl[0]  = '{1'b1, BASE + 32'h00, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      tbl[2]  = '{1'b0, BASE + 32'h10, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
      tbl[3]  = '{1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
      tbl[4]  = '{1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0};
      tbl[5]  = '{1'b0, BASE + 32'h20, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD};
      tbl[6]  = '{1'b1, BASE + 32'h22, 32'h5566_7788, 4'b1000, 2'b00, 32'h0};
      tbl[7]  = '{1'b0, BASE + 32'h21, 32'h0, 4'h0, 2'b00, 32'h55BB_33DD};
      tbl[8]  = '{1'b1, BASE + 32'h40, 32'hCAFE_F00D, 4'hF, RC ? 2'b10 : 2'b00, 32'h0};
      tbl[9]  = '{1'b0, BASE + 32'h40, 32'h0, 4'h0, RC ? 2'b10 : 2'b00, RC ? 32'h0 : 32'hCAFE_F00D};
      tbl[10] = '{1'b0, BASE + 32'h00, 32'h0, 4'h0, 2'b00, RC ? 32'h0BAD_F00D : 32'hCAFE_F00D};
      tbl[11] = '{1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
      tbl[12] = '{1'b0, BASE - 32'h4, 32'h0, 4'h0, RC ? 2'b10 : 2'b00, RC ? 32'h0 : 32'hFFFF_FFFF};
      tbl[13] = '{1'b1, BASE - 32'h4, 32'h1234_5678, 4'hF, RC ? 2'b10 : 2'b00, 32'h0};
      tbl[14] = '{1'b0, BASE + 32'h3C, 32'h0, 4'h0, 2'b00, RC ? 32'hFFFF_FFFF : 32'h1234_5678};

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
            chk("tbl_bresp", 32'(r), 32'(tbl[i].resp));
            mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
         end else begin
            axi_read(tbl[i].addr, r, d);
            chk("tbl_rresp", 32'(r), 32'(tbl[i].resp));
            chk("tbl_rdata", d, tbl[i].rdata);
         end
      end

      // Simultaneous requests: grants must alternate starting with the write.
      @(negedge clk);
      axi.awaddr = BASE + 32'h30; axi.wdata = 32'h0F0F_A5A5; axi.wstrb = 4'hF;
      axi.araddr = BASE + 32'h10;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      axi.bready = 1'b1; axi.rready = 1'b1;
      g = 4'b0000; got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         #1;
         chk("two_readies", 32'(axi.awready && axi.arready), 32'd0);
         if (axi.awready && axi.wready) begin g[got] = 1'b1; got++; end
         else if (axi.arready) begin g[got] = 1'b0; got++; end
         if (got < 4) @(negedge clk);
      end
      chk("grant_count", 32'(got), 32'd4);
      chk("grant_order", 32'(g), 32'b0101);
      @(posedge clk);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      axi.bready = 1'b0; axi.rready = 1'b0;
      mdl_write(BASE + 32'h30, 32'h0F0F_A5A5, 4'hF);
      axi_read(BASE + 32'h30, r, d);
      chk("tie_rdata", d, exp_rdata(BASE + 32'h30));

      // Stalled write response holds off a waiting read.
      @(negedge clk);
      axi.awaddr = BASE + 32'h14; axi.wdata = 32'h7654_3210; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      #1;
      chk("stall_wgrant", 32'(axi.awready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.araddr = BASE + 32'h14; axi.arvalid = 1'b1;
      mdl_write(BASE + 32'h14, 32'h7654_3210, 4'hF);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_bvalid", 32'(axi.bvalid), 32'd1);
         chk("stall_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'd0);
         @(negedge clk);
      end
      axi.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.bready = 1'b0;
      #1;
      chk("ar_after_b", 32'(axi.arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.arvalid = 1'b0;
      #1;
      chk("stall_rvalid", 32'(axi.rvalid), 32'd1);
      chk("stall_rdata", axi.rdata, exp_rdata(BASE + 32'h14));
      axi.rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.rready = 1'b0;

      // Reset while a read response is stalled.
      @(negedge clk);
      axi.araddr = BASE + 32'h10; axi.arvalid = 1'b1;
      #1;
      chk("rrst_grant", 32'(axi.arready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.arvalid = 1'b0;
      #1;
      chk("rrst_rvalid_pre", 32'(axi.rvalid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rrst_rvalid", 32'(axi.rvalid), 32'd0);
      chk("rrst_rdata", axi.rdata, 32'd0);
      axi_read(BASE + 32'h10, r, d);
      chk("rrst_after", d, exp_rdata(BASE + 32'h10));

      // Reset during a stalled write response keeps the committed write.
      @(negedge clk);
      axi.awaddr = BASE + 32'h18; axi.wdata = 32'h600D_CAFE; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      #1;
      chk("wrst_grant", 32'(axi.awready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      mdl_write(BASE + 32'h18, 32'h600D_CAFE, 4'hF);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("wrst_bvalid", 32'(axi.bvalid), 32'd0);
      axi_read(BASE + 32'h18, r, d);
      chk("wrst_rdata", d, exp_rdata(BASE + 32'h18));

      // Randomized traffic against the array model.
      for (int i = 0; i < 40; i++) begin
         a = BASE + 32'($urandom_range(0, 19) << 2) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = BASE - 32'(4 * $urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, r);
            chk("rnd_bresp", 32'(r), 32'(exp_resp(a)));
            mdl_write(a, d, s);
         end else begin
            axi_read(a, r, d);
            chk("rnd_rresp", 32'(r), 32'(exp_resp(a)));
            chk("rnd_rdata", d, exp_rdata(a));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
